// File: rtl/ps2_keyboard_interface.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes bytes and
// translates paddle keys into a held-key code. Optional: PS2_PARITY_CHECK_EN drops bad-parity frames.
module ps2_keyboard_interface #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clock,
   input  logic       resetn,
   inout  wire        ps2_clock,
   inout  wire        ps2_data,
   output logic [7:0] ps2_key_data,
   output logic       ps2_key_pressed,
   output logic [7:0] ps2_out
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [7:0] {
      KEY_NONE = 8'h00,
      KEY_W    = 8'h01,
      KEY_S    = 8'h02,
      KEY_UP   = 8'h03,
      KEY_DOWN = 8'h04
   } key_e;

   // The PS/2 lines are never driven here; they are only read.
   logic          clk_meta, clk_sync, dat_meta, dat_sync;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;
   logic [TW-1:0] idle_cnt;
   logic          ext, brk;
   logic          fall, frame_ok;
   key_e          make_code;

   // A falling edge is accepted on the same cycle the filtered clock drops.
   assign fall = clk_filt && !clk_sync && (filt_cnt == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat_sync && (^shift);
`else
   assign frame_ok = dat_sync;
`endif

   // NOTE: always_comb gives make_code a default first so no path leaves it unassigned (no latch).
   always_comb begin
      make_code = KEY_NONE;
      if (!ext) begin
         case (ps2_key_data)
            8'h1D:   make_code = KEY_W;
            8'h1B:   make_code = KEY_S;
            default: make_code = KEY_NONE;
         endcase
      end else begin
         case (ps2_key_data)
            8'h75:   make_code = KEY_UP;
            8'h72:   make_code = KEY_DOWN;
            default: make_code = KEY_NONE;
         endcase
      end
   end

   // NOTE: all state uses non-blocking assignments so every register sees the pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         clk_meta        <= 1'b1;
         clk_sync        <= 1'b1;
         dat_meta        <= 1'b1;
         dat_sync        <= 1'b1;
         clk_filt        <= 1'b1;
         filt_cnt        <= '0;
         bit_cnt         <= '0;
         shift           <= '0;
         idle_cnt        <= '0;
         ext             <= 1'b0;
         brk             <= 1'b0;
         ps2_key_data    <= '0;
         ps2_key_pressed <= 1'b0;
         ps2_out         <= '0;
      end else begin
         clk_meta <= ps2_clock;
         clk_sync <= clk_meta;
         dat_meta <= ps2_data;
         dat_sync <= dat_meta;

         if (clk_sync != clk_filt) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               clk_filt <= clk_sync;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end

         ps2_key_pressed <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd0) begin
               if (!dat_sync) bit_cnt <= 4'd1;
            end else if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
               if (frame_ok) begin
                  ps2_key_data    <= shift[7:0];
                  ps2_key_pressed <= 1'b1;
               end
            end else begin
               shift   <= {dat_sync, shift[8:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled partial frame is abandoned so the next start bit realigns.
            if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
               bit_cnt  <= 4'd0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + TW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end

         if (ps2_key_pressed) begin
            if (ps2_key_data == 8'hE0) begin
               ext <= 1'b1;
            end else if (ps2_key_data == 8'hF0) begin
               brk <= 1'b1;
            end else if (brk) begin
               ps2_out <= KEY_NONE;
               brk     <= 1'b0;
               ext     <= 1'b0;
            end else begin
               ps2_out <= make_code;
               ext     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_interface.sv
// Self-checking bench for ps2_keyboard_interface: table of frames plus hand sequences for
// glitches, timeout, spurious start bit and mid-frame reset; strobed bytes checked via a scoreboard.
module tb_ps2_keyboard_interface;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       clk_drv = 1'b1;
   logic       dat_drv = 1'b1;
   wire        ps2_clock_w;
   wire        ps2_data_w;
   logic [7:0] ps2_key_data;
   logic       ps2_key_pressed;
   logic [7:0] ps2_out;

   assign ps2_clock_w = clk_drv;
   assign ps2_data_w  = dat_drv;

   ps2_keyboard_interface #(
      .FILTER_LEN (8),
      .TIMEOUT_CYC(2000)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .ps2_clock      (ps2_clock_w),
      .ps2_data       (ps2_data_w),
      .ps2_key_data   (ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed),
      .ps2_out        (ps2_out)
   );

   always #10 clock = ~clock;

   typedef struct {
      logic [7:0] data;
      logic       par_ok;
      logic       stop;
      logic       strobe;
      logic [7:0] out;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   int         strobes = 0;
   int         exp_strobes = 0;
   logic [7:0] sb[$];
   logic       prev_pressed = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input logic [7:0] b);
      sb.push_back(b);
      exp_strobes++;
   endtask

   // Sends the first nbits of a frame; optional 3-cycle clock glitches in each high phase.
   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop,
                             input int nbits, input bit glitch);
      logic [10:0] bits;
      logic        par;
      par  = (~^d) ^ ~par_ok;
      bits = {stop, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dat_drv = bits[i];
         if (glitch) begin
            cyc(5);
            repeat (3) begin
               clk_drv = 1'b0;
               cyc(3);
               clk_drv = 1'b1;
               cyc(5);
            end
         end
         cyc(20);
         clk_drv = 1'b0;
         cyc(40);
         clk_drv = 1'b1;
         cyc(20);
      end
      dat_drv = 1'b1;
   endtask

   always @(negedge clock) begin
      if (resetn && ps2_key_pressed) begin
         strobes++;
         if (prev_pressed) begin
            total++;
            bad++;
            $display("FAIL strobe_width: strobe held for more than 1 cycle at %0t", $time);
         end
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got byte %0h, none expected at %0t", ps2_key_data, $time);
         end else begin
            check("key_data", {24'd0, ps2_key_data}, {24'd0, sb.pop_front()});
         end
      end
      prev_pressed = ps2_key_pressed;
   end

   initial begin
      vec_t vecs[15];
      vecs[0]  = '{8'h1D, 1'b1, 1'b1, 1'b1, 8'h01};
      vecs[1]  = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'h01};
      vecs[2]  = '{8'h1D, 1'b1, 1'b1, 1'b1, 8'h00};
      vecs[3]  = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'h00};
      vecs[4]  = '{8'h75, 1'b1, 1'b1, 1'b1, 8'h03};
      vecs[5]  = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'h03};
      vecs[6]  = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'h03};
      vecs[7]  = '{8'h75, 1'b1, 1'b1, 1'b1, 8'h00};
      vecs[8]  = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'h00};
      vecs[9]  = '{8'h72, 1'b1, 1'b1, 1'b1, 8'h04};
      vecs[10] = '{8'h1B, 1'b1, 1'b1, 1'b1, 8'h02};
      vecs[11] = '{8'h1D, 1'b1, 1'b1, 1'b1, 8'h01};
      vecs[12] = '{8'h1D, 1'b1, 1'b1, 1'b1, 8'h01};
      vecs[13] = '{8'h1B, 1'b1, 1'b0, 1'b0, 8'h01};
`ifdef PS2_PARITY_CHECK_EN
      vecs[14] = '{8'h1B, 1'b0, 1'b1, 1'b0, 8'h01};
`else
      vecs[14] = '{8'h1B, 1'b0, 1'b1, 1'b1, 8'h02};
`endif

      resetn = 1'b0;
      cyc(2);
      check("rst_out", {24'd0, ps2_out}, 32'h0);
      check("rst_key_data", {24'd0, ps2_key_data}, 32'h0);
      check("rst_pressed", {31'd0, ps2_key_pressed}, 32'h0);
      resetn = 1'b1;
      cyc(5);

      foreach (vecs[i]) begin
         if (vecs[i].strobe) push(vecs[i].data);
         send_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop, 11, 1'b0);
         cyc(4);
         check($sformatf("vec%0d_out", i), {24'd0, ps2_out}, {24'd0, vecs[i].out});
         check($sformatf("vec%0d_sb", i), sb.size(), 0);
      end

      // Clock glitches inside each bit must not be counted as edges.
      push(8'hE0);
      send_frame(8'hE0, 1'b1, 1'b1, 11, 1'b1);
      push(8'h72);
      send_frame(8'h72, 1'b1, 1'b1, 11, 1'b1);
      cyc(4);
      check("glitch_out", {24'd0, ps2_out}, 32'h04);
      check("glitch_sb", sb.size(), 0);

      // Partial frame abandoned after the idle timeout.
      send_frame(8'h00, 1'b1, 1'b1, 5, 1'b0);
      cyc(2500);
      push(8'h1B);
      send_frame(8'h1B, 1'b1, 1'b1, 11, 1'b0);
      cyc(4);
      check("timeout_out", {24'd0, ps2_out}, 32'h02);
      check("timeout_key", {24'd0, ps2_key_data}, 32'h1B);
      check("timeout_sb", sb.size(), 0);

      // A falling edge with data high is not a start bit.
      dat_drv = 1'b1;
      cyc(20);
      clk_drv = 1'b0;
      cyc(40);
      clk_drv = 1'b1;
      cyc(20);
      push(8'h1D);
      send_frame(8'h1D, 1'b1, 1'b1, 11, 1'b0);
      cyc(4);
      check("start1_out", {24'd0, ps2_out}, 32'h01);
      check("start1_sb", sb.size(), 0);

      // Reset in the middle of a frame discards it.
      send_frame(8'h1B, 1'b1, 1'b1, 5, 1'b0);
      resetn = 1'b0;
      cyc(2);
      check("midrst_out", {24'd0, ps2_out}, 32'h0);
      check("midrst_key", {24'd0, ps2_key_data}, 32'h0);
      resetn = 1'b1;
      cyc(5);
      push(8'h1B);
      send_frame(8'h1B, 1'b1, 1'b1, 11, 1'b0);
      cyc(4);
      check("midrst_after_out", {24'd0, ps2_out}, 32'h02);
      check("midrst_after_sb", sb.size(), 0);

      cyc(10);
      check("strobe_count", strobes, exp_strobes);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
